// File: rtl/brick_pkg.sv
// Shared types and grid geometry for the brick-hit sequencer.
package brick_pkg;

    localparam int BLOCK_SIZE_LOG2   = 5;
    localparam int BLOCKS_PER_ROW    = 17;
    localparam int BLOCKS_PER_COLUMN = 14;

    typedef struct packed {
        logic [4:0] x;
        logic [3:0] y;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } seq_state_t;

endpackage

// File: rtl/hit_fifo.sv
// Small synchronous FIFO of grid cells; a pop frees a slot for a same-cycle push even when full.
module hit_fifo
    import brick_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  cell_t         push_data,
    input  logic          pop,
    output cell_t         pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    cell_t          mem_q [DEPTH];
    cell_t          mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/brick_hit_sequencer.sv
// Turns per-pixel bullet/brick overlaps into de-duplicated, spaced single-cell damage requests.
module brick_hit_sequencer
    import brick_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SEEN_DEPTH   = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    input  logic        bulletBrickHit,
    input  logic        startOfFrame,
    output logic [4:0]  brickCollision1X,
    output logic [3:0]  brickCollision1Y,
    output logic        collision,
    output logic [2:0]  pendingCount,
    output logic        overflow
);

    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam int SCW  = $clog2(SEEN_DEPTH + 1);
    localparam int SIW  = $clog2(SEEN_DEPTH);
    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNTW = $clog2(MAXC + 1);

    logic [10:0]    dx, dy;
    logic           in_grid;
    logic           s1_vld_q, s1_vld_d;
    cell_t          s1_cell_q, s1_cell_d;
    cell_t          seen_q [SEEN_DEPTH];
    cell_t          seen_d [SEEN_DEPTH];
    logic [SCW-1:0] seen_cnt_q, seen_cnt_d, seen_cnt_eff;
    logic           seen_hit;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    cell_t          fifo_head;
    logic [FCW-1:0] fifo_count;
    logic           overflow_q, overflow_d;
    seq_state_t     state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    cell_t          addr_q, addr_d;
    logic           collision_q, collision_d;

    // Stage 1: pixel -> cell, rejecting anything left/above the origin or past the grid.
    always_comb begin
        dx = pixelX - topLeftX;
        dy = pixelY - topLeftY;
        in_grid = (pixelX >= topLeftX) && (pixelY >= topLeftY) &&
                  ((dx >> BLOCK_SIZE_LOG2) < 11'(BLOCKS_PER_ROW)) &&
                  ((dy >> BLOCK_SIZE_LOG2) < 11'(BLOCKS_PER_COLUMN));
        s1_vld_d  = bulletBrickHit && in_grid;
        s1_cell_d = s1_cell_q;
        if (s1_vld_d) s1_cell_d = '{x: dx[9:5], y: dy[8:5]};
    end

    // Stage 2: a frame start empties the seen-list before this cycle's compare.
    always_comb begin
        seen_cnt_eff = startOfFrame ? '0 : seen_cnt_q;
        seen_hit     = 1'b0;
        for (int i = 0; i < SEEN_DEPTH; i++) begin
            if ((SCW'(i) < seen_cnt_eff) && (seen_q[i] == s1_cell_q)) seen_hit = 1'b1;
        end
        fifo_push = s1_vld_q && !seen_hit && (seen_cnt_eff < SCW'(SEEN_DEPTH)) &&
                    (!fifo_full || fifo_pop);
        seen_d     = seen_q;
        seen_cnt_d = seen_cnt_eff;
        if (fifo_push) begin
            seen_d[seen_cnt_eff[SIW-1:0]] = s1_cell_q;
            seen_cnt_d                    = seen_cnt_eff + SCW'(1);
        end
        overflow_d = overflow_q | (s1_vld_q && !seen_hit && !fifo_push);
    end

    hit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (s1_cell_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // collision is registered from the state, so it trails PULSE entry by one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        fifo_pop    = 1'b0;
        collision_d = (state_q == PULSE);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_head;
                    cnt_d    = '0;
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == CNTW'(PULSE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNTW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q    <= 1'b0;
            s1_cell_q   <= '0;
            seen_q      <= '{default: '0};
            seen_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_cell_q   <= s1_cell_d;
            seen_q      <= seen_d;
            seen_cnt_q  <= seen_cnt_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            collision_q <= collision_d;
        end
    end

    assign brickCollision1X = addr_q.x;
    assign brickCollision1Y = addr_q.y;
    assign collision        = collision_q;
    assign pendingCount     = 3'(fifo_count);
    assign overflow         = overflow_q;

endmodule

// File: doc/brick_hit_sequencer.md
Name: brick_hit_sequencer

Overview:
- Sits directly upstream of the brick-matrix stage. Converts raw per-pixel bullet/brick overlap events into clean, one-at-a-time brick-damage requests: cell X/Y plus a collision pulse.
- Maps screen pixels to 32x32 grid cells and suppresses repeats of the same cell within a frame.
- Queues distinct hits and spaces the pulses so the matrix stage's edge-detect (collision must drop low between hits) never merges two hits.

Parameters:
- FIFO_DEPTH, 4, pending-hit queue entries (power of 2)
- SEEN_DEPTH, 8, distinct cells recordable per frame for de-duplication
- PULSE_CYCLES, 2, cycles collision is held high per hit
- GAP_CYCLES, 2, cycles collision is held low after each pulse

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixelX  in  11  current VGA pixel X
- pixelY  in  11  current VGA pixel Y
- topLeftX  in  11  grid origin X
- topLeftY  in  11  grid origin Y
- bulletBrickHit  in  1  bullet pixel and brick drawingRequest both asserted this pixel
- startOfFrame  in  1  one-cycle pulse at frame start
- brickCollision1X  out  5  target cell column, 0..16
- brickCollision1Y  out  4  target cell row, 0..13
- collision  out  1  damage request to matrix stage
- pendingCount  out  3  FIFO occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: a distinct hit was dropped

Behaviour:
- Reset (sampled on clk rise while reset=1):
  - all outputs 0, FIFO empty, seen-list empty, FSM IDLE.
  - Reset mid-pulse forces collision=0 on the next cycle and discards pending hits.
- Stage 1 (registered), at the edge sampling bulletBrickHit=1:
  - dx = pixelX-topLeftX, dy = pixelY-topLeftY, 11-bit unsigned.
  - Valid only if pixelX>=topLeftX, pixelY>=topLeftY, dx>>5 < 17 and dy>>5 < 14; otherwise the hit is silently dropped.
  - cell = {dx[9:5], dy[8:5]}.
- Stage 2: the registered cell is compared against all valid seen-list entries.
  - Match: drop, overflow unaffected.
  - No match, seen-list not full and FIFO not full: append to seen-list and push to FIFO.
  - No match and either list full: drop and set overflow. overflow clears only on reset.
- startOfFrame:
  - clears the seen-list.
  - If it coincides with a stage-2 compare, the clear wins: the hit is compared against an empty list and becomes its first entry.
  - Does not affect the FIFO or the FSM.
- FIFO: push and pop in the same cycle are legal at any occupancy, including full, where the pop frees the slot. pendingCount reflects the post-edge occupancy.
- Output FSM:
  - IDLE: collision=0. If FIFO not empty, pop the head, register it onto brickCollision1X/Y, go to PULSE.
  - PULSE: collision=1 for exactly PULSE_CYCLES cycles, then go to GAP.
  - GAP: collision=0 for exactly GAP_CYCLES cycles, then go to IDLE.
  - brickCollision1X/Y are stable from PULSE entry through GAP exit. They hold their last value in IDLE.
- Latency: with an empty pipe, a hit sampled at edge 0 yields collision=1 from edge 3, with address valid at the same edge.
- Back-to-back queued hits: rising edges of collision are PULSE_CYCLES+GAP_CYCLES+1 cycles apart (IDLE lasts one cycle).
- A continuous bulletBrickHit across one cell's pixels generates exactly one request per frame.

Decomposition:
- Package brick_pkg:
  - BLOCK_SIZE_LOG2=5, BLOCKS_PER_ROW=17, BLOCKS_PER_COLUMN=14
  - typedef cell_t struct packed {logic [4:0] x; logic [3:0] y;}
  - typedef enum seq_state_t {IDLE, PULSE, GAP}
- Sub-module hit_fifo: synchronous cell_t FIFO with push, pop, full, empty and count.

Test Plan:
- Origin (0,0); bulletBrickHit for pixels (70,100)..(80,100) -> exactly one request, X=2 Y=3; collision high edges 3-4, low edges 5-6.
- Hits at cells (1,1), (5,2), (16,13) in one cycle each, consecutive -> three requests in order; collision rising edges 5 cycles apart; pendingCount peaks at 2.
- Same cell hit in frame N, startOfFrame, hit again in frame N+1 -> two requests; a repeat within frame N -> none.
- Origin (32,0): hits at pixelX=20 and at pixelX=32+544 -> no request, overflow stays 0.
- Hold the FSM busy, inject 6 distinct cells -> first 5 accepted (1 in flight + 4 queued), sixth dropped, overflow=1 until reset.
- Assert reset during PULSE -> collision=0, pendingCount=0 next cycle; after release, a fresh hit produces a normal 3-cycle-latency request.
